// File: rtl/cnn_stage_sequencer.sv
// Sequencer for the CNN layer chain: releases stages strictly in order, waits for each
// stage's done, watches each stage with a watchdog and records per-stage and total latency.
module cnn_stage_sequencer #(
    parameter int NUM_STAGES   = 6,
    parameter int CNT_W        = 24,
    parameter int TIMEOUT      = 2000000,
    parameter int REARM_CYCLES = 2,
    parameter int SEL_W        = 3
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [NUM_STAGES-1:0] stage_done_i,
    output logic [NUM_STAGES-1:0] stage_rstn_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  result_valid_o,
    output logic                  error_o,
    output logic [SEL_W-1:0]      err_stage_o,
    output logic [CNT_W-1:0]      total_cycles_o,
    input  logic [SEL_W-1:0]      lat_sel_i,
    output logic [CNT_W-1:0]      stage_lat_o
);

    localparam int REARM_EFF = (REARM_CYCLES < 1) ? 1 : REARM_CYCLES;
    localparam int RW        = (REARM_EFF > 1) ? $clog2(REARM_EFF) : 1;
    localparam logic [RW-1:0]         REARM_LAST = RW'(REARM_EFF - 1);
    localparam logic [CNT_W-1:0]      CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]      TO_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [SEL_W-1:0]      LAST_STAGE = SEL_W'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0] ALL_OFF    = {NUM_STAGES{1'b0}};
    localparam logic [NUM_STAGES-1:0] ALL_ON     = {NUM_STAGES{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REARM = 3'd1,
        S_RUN   = 3'd2,
        S_HOLD  = 3'd3,
        S_ERR   = 3'd4
    } state_e;

    state_e                  state_q, state_d;
    logic [SEL_W-1:0]        cur_q, cur_d;
    logic [RW-1:0]           rearm_q, rearm_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CNT_W-1:0]        total_q, total_d;
    logic [CNT_W-1:0]        lat_q [NUM_STAGES];
    logic [CNT_W-1:0]        lat_d [NUM_STAGES];
    logic [NUM_STAGES-1:0]   rstn_q, rstn_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    valid_q, valid_d;
    logic                    error_q, error_d;
    logic [SEL_W-1:0]        err_stage_q, err_stage_d;
    logic                    done_sel_s;
    logic                    qual_s;
    logic                    start_acc_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    function automatic logic [NUM_STAGES-1:0] run_mask(input logic [SEL_W-1:0] c);
        run_mask = ALL_OFF;
        for (int k = 0; k < NUM_STAGES; k++) begin
            run_mask[k] = (SEL_W'(k) <= c);
        end
    endfunction

    // Pick the done line of the active stage; a done seen while cnt is still 0 is stale.
    always_comb begin
        done_sel_s = 1'b0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            done_sel_s = done_sel_s | (stage_done_i[k] & (SEL_W'(k) == cur_q));
        end
        qual_s = done_sel_s & (cnt_q != {CNT_W{1'b0}});
    end

    // Latency readback mux; selects beyond the last stage read as zero.
    always_comb begin
        stage_lat_o = {CNT_W{1'b0}};
        for (int k = 0; k < NUM_STAGES; k++) begin
            stage_lat_o = stage_lat_o | (lat_q[k] & {CNT_W{(SEL_W'(k) == lat_sel_i)}});
        end
    end

    // Next-state and next-output logic of the sequencer.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        rearm_d     = rearm_q;
        cnt_d       = cnt_q;
        total_d     = total_q;
        lat_d       = lat_q;
        rstn_d      = rstn_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        valid_d     = valid_q;
        error_d     = error_q;
        err_stage_d = err_stage_q;
        start_acc_s = 1'b0;
        case (state_q)
            S_IDLE, S_ERR: begin
                start_acc_s = start_i & ~abort_i;
            end
            S_HOLD: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                    rstn_d  = ALL_OFF;
                    valid_d = 1'b0;
                end else begin
                    start_acc_s = start_i;
                end
            end
            S_REARM: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                    rstn_d  = ALL_OFF;
                    busy_d  = 1'b0;
                end else if (rearm_q == REARM_LAST) begin
                    state_d = S_RUN;
                    cur_d   = {SEL_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    total_d = {CNT_W{1'b0}};
                    rstn_d  = run_mask({SEL_W{1'b0}});
                end else begin
                    rearm_d = rearm_q + RW'(1);
                end
            end
            S_RUN: begin
                if (abort_i) begin
                    state_d = S_IDLE;
                    rstn_d  = ALL_OFF;
                    busy_d  = 1'b0;
                end else if (qual_s) begin
                    for (int k = 0; k < NUM_STAGES; k++) begin
                        lat_d[k] = (SEL_W'(k) == cur_q) ? cnt_q : lat_q[k];
                    end
                    if (cur_q == LAST_STAGE) begin
                        state_d = S_HOLD;
                        rstn_d  = ALL_ON;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        valid_d = 1'b1;
                    end else begin
                        cur_d   = cur_q + SEL_W'(1);
                        cnt_d   = {CNT_W{1'b0}};
                        rstn_d  = run_mask(cur_q + SEL_W'(1));
                        total_d = sat_inc(total_q);
                    end
                end else if (cnt_q == TO_LAST) begin
                    state_d     = S_ERR;
                    rstn_d      = ALL_OFF;
                    busy_d      = 1'b0;
                    error_d     = 1'b1;
                    err_stage_d = cur_q;
                end else begin
                    cnt_d   = sat_inc(cnt_q);
                    total_d = sat_inc(total_q);
                end
            end
            default: begin
                state_d = S_IDLE;
                rstn_d  = ALL_OFF;
                busy_d  = 1'b0;
            end
        endcase
        // An accepted start wipes the previous run's results before rearming.
        if (start_acc_s) begin
            state_d     = S_REARM;
            rearm_d     = {RW{1'b0}};
            rstn_d      = ALL_OFF;
            busy_d      = 1'b1;
            valid_d     = 1'b0;
            error_d     = 1'b0;
            err_stage_d = {SEL_W{1'b0}};
            total_d     = {CNT_W{1'b0}};
            for (int k = 0; k < NUM_STAGES; k++) begin
                lat_d[k] = {CNT_W{1'b0}};
            end
        end else begin
            start_acc_s = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= S_IDLE;
            cur_q       <= {SEL_W{1'b0}};
            rearm_q     <= {RW{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            total_q     <= {CNT_W{1'b0}};
            rstn_q      <= ALL_OFF;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
            err_stage_q <= {SEL_W{1'b0}};
            for (int k = 0; k < NUM_STAGES; k++) begin
                lat_q[k] <= {CNT_W{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            rearm_q     <= rearm_d;
            cnt_q       <= cnt_d;
            total_q     <= total_d;
            rstn_q      <= rstn_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            valid_q     <= valid_d;
            error_q     <= error_d;
            err_stage_q <= err_stage_d;
            for (int k = 0; k < NUM_STAGES; k++) begin
                lat_q[k] <= lat_d[k];
            end
        end
    end

    assign stage_rstn_o   = rstn_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign result_valid_o = valid_q;
    assign error_o        = error_q;
    assign err_stage_o    = err_stage_q;
    assign total_cycles_o = total_q;

endmodule

// File: tb/tb_cnn_stage_sequencer.sv
// Bench for cnn_stage_sequencer: emulated stages with programmable done delays, a table of
// hand-computed runs, randomized runs against an arithmetic timing model, and corner sequences.
module tb_cnn_stage_sequencer;

    localparam int NS = 3;
    localparam int CW = 24;
    localparam int TO = 16;
    localparam int RC = 2;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rstn;
    logic          start;
    logic          abort;
    logic [NS-1:0] sdone;
    logic [NS-1:0] srstn;
    logic          busy;
    logic          done;
    logic          rvalid;
    logic          error;
    logic [SW-1:0] err_stage;
    logic [CW-1:0] total;
    logic [SW-1:0] lat_sel;
    logic [CW-1:0] stage_lat;

    cnn_stage_sequencer #(
        .NUM_STAGES(NS), .CNT_W(CW), .TIMEOUT(TO), .REARM_CYCLES(RC), .SEL_W(SW)
    ) dut (
        .clk_i(clk), .rstn_i(rstn), .start_i(start), .abort_i(abort),
        .stage_done_i(sdone), .stage_rstn_o(srstn), .busy_o(busy), .done_o(done),
        .result_valid_o(rvalid), .error_o(error), .err_stage_o(err_stage),
        .total_cycles_o(total), .lat_sel_i(lat_sel), .stage_lat_o(stage_lat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d0, d1, d2;
        int exp_end;
        int exp_total;
        int exp_err;
        int exp_es;
    } vec_t;

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            plan_d [NS];
    int            up [NS];
    logic [NS-1:0] force_done;
    vec_t          vecs [7];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock: sample after the edge, then let each emulated stage raise done
    // once it has been out of reset for its programmed number of cycles.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < NS; k++) begin
            up[k]    = srstn[k] ? up[k] + 1 : 0;
            sdone[k] = force_done[k] | (up[k] > plan_d[k]);
        end
    endtask

    // Event-level model: each stage occupies (delay + 1) cycles, a delay >= TO times out.
    task automatic plan(input int d0, d1, d2, output int e_end, e_tot, e_err, e_es);
        int d [NS];
        int off;
        int tot;
        d = '{d0, d1, d2};
        off = 1 + RC; tot = 0; e_err = 0; e_es = 0; e_end = 0; e_tot = 0;
        for (int k = 0; k < NS; k++) begin
            if (e_err == 0) begin
                if (d[k] >= TO) begin
                    e_err = 1; e_es = k; e_end = off + TO;
                end else begin
                    off += d[k] + 1;
                    tot += d[k] + 1;
                end
            end
        end
        if (e_err == 0) begin
            e_end = off;
            e_tot = tot - 1;
        end
    endtask

    task automatic run_trial(input int d0, d1, d2, input int e_end, e_total, e_err, e_es,
                             input string tag);
        int d [NS];
        longint r [NS];
        int t, endc, errk, done_k, obs;
        logic [NS-1:0] m;
        logic ex_err, ex_hold;
        d = '{d0, d1, d2};
        plan_d = d;
        for (int k = 0; k < NS; k++) r[k] = 64'd1000000000;
        errk = -1;
        endc = 0;
        t = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        r[0] = t + 1 + RC;
        for (int k = 0; k < NS; k++) begin
            if (errk < 0) begin
                if (k > 0) r[k] = r[k-1] + d[k-1] + 1;
                if (d[k] >= TO) begin
                    errk = k;
                    endc = int'(r[k]) + TO;
                end
            end
        end
        if (errk < 0) endc = int'(r[NS-1]) + d[NS-1] + 1;
        obs = -1;
        while (cyc <= endc + 1) begin
            ex_err  = (errk >= 0) && (cyc >= endc);
            ex_hold = (errk < 0) && (cyc >= endc);
            for (int k = 0; k < NS; k++) m[k] = (r[k] <= cyc);
            if (ex_err) m = '0;
            else if (ex_hold) m = '1;
            chk({tag, " stage_rstn"}, srstn, m);
            chk({tag, " busy"}, busy, (cyc < endc));
            chk({tag, " done"}, done, (ex_hold && cyc == endc));
            chk({tag, " result_valid"}, rvalid, ex_hold);
            chk({tag, " error"}, error, ex_err);
            if (obs < 0 && (done || error)) obs = cyc - t;
            tick();
        end
        chk({tag, " end_offset"}, obs, e_end);
        if (e_err == 0) chk({tag, " total_cycles"}, total, e_total);
        chk({tag, " error_final"}, error, e_err);
        chk({tag, " err_stage"}, err_stage, e_es);
        done_k = (e_err != 0) ? e_es : NS;
        for (int k = 0; k < NS; k++) begin
            lat_sel = SW'(k);
            #1;
            chk({tag, $sformatf(" stage_lat[%0d]", k)}, stage_lat, (k < done_k) ? d[k] : 0);
        end
        lat_sel = SW'(3);
        #1;
        chk({tag, " stage_lat out_of_range"}, stage_lat, 0);
        lat_sel = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int t, e_end, e_tot, e_err, e_es, a, b, c;

        vecs[0] = '{5, 3, 7, 21, 17, 0, 0};
        vecs[1] = '{1, 1, 1, 9, 5, 0, 0};
        vecs[2] = '{15, 2, 4, 27, 23, 0, 0};
        vecs[3] = '{4, 20, 3, 24, 0, 1, 1};
        vecs[4] = '{5, 3, 7, 21, 17, 0, 0};
        vecs[5] = '{16, 2, 2, 19, 0, 1, 0};
        vecs[6] = '{1, 1, 1, 9, 5, 0, 0};

        rstn = 1'b0; start = 1'b0; abort = 1'b0; lat_sel = '0;
        force_done = '0; sdone = '0;
        for (int k = 0; k < NS; k++) begin
            plan_d[k] = 1;
            up[k] = 0;
        end
        repeat (3) tick();
        chk("reset stage_rstn", srstn, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset result_valid", rvalid, 0);
        chk("reset error", error, 0);
        chk("reset err_stage", err_stage, 0);
        chk("reset total", total, 0);
        chk("reset stage_lat0", stage_lat, 0);
        rstn = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 7; i++) begin
            run_trial(vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].exp_end, vecs[i].exp_total,
                      vecs[i].exp_err, vecs[i].exp_es, $sformatf("vec%0d", i));
        end

        // Stage 1's done is stuck high from before its release.
        force_done = 3'b010;
        run_trial(3, 1, 2, 12, 8, 0, 0, "stale");
        force_done = '0;

        for (int i = 0; i < 12; i++) begin
            a = $urandom_range(1, 18);
            b = $urandom_range(1, 18);
            c = $urandom_range(1, 18);
            plan(a, b, c, e_end, e_tot, e_err, e_es);
            run_trial(a, b, c, e_end, e_tot, e_err, e_es, $sformatf("rnd%0d", i));
        end

        // Abort while stage 1 runs.
        plan_d = '{2, 10, 10};
        t = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc < t + 7) tick();
        chk("abort pre stage_rstn", srstn, 3'b011);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort stage_rstn", srstn, 0);
        chk("abort busy", busy, 0);
        chk("abort result_valid", rvalid, 0);
        lat_sel = SW'(0);
        #1;
        chk("abort kept stage_lat0", stage_lat, 2);
        for (int i = 0; i < 6; i++) begin
            chk("abort no done", done, 0);
            chk("abort idle stage_rstn", srstn, 0);
            tick();
        end

        // start together with abort is ignored.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("start+abort busy", busy, 0);
            chk("start+abort stage_rstn", srstn, 0);
            tick();
        end

        // Reset while the last stage runs.
        plan_d = '{5, 3, 7};
        t = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (cyc < t + 14) tick();
        chk("midreset pre stage_rstn", srstn, 3'b111);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("midreset stage_rstn", srstn, 0);
        chk("midreset busy", busy, 0);
        chk("midreset done", done, 0);
        chk("midreset result_valid", rvalid, 0);
        chk("midreset error", error, 0);
        chk("midreset err_stage", err_stage, 0);
        chk("midreset total", total, 0);
        for (int k = 0; k < NS; k++) begin
            lat_sel = SW'(k);
            #1;
            chk($sformatf("midreset stage_lat[%0d]", k), stage_lat, 0);
        end
        lat_sel = '0;
        tick();
        run_trial(1, 1, 1, 9, 5, 0, 0, "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
